// File: rtl/ryu_pkg.sv
// Shared types and constants for the Ryu sprite path.
// Used by the sprite fetch stage and the palette.
package ryu_pkg;

  localparam int SPR_W_DEF  = 64;
  localparam int SPR_H_DEF  = 96;
  localparam int FRAMES_DEF = 4;
  localparam int HOLD_DEF   = 6;

  // Magenta key entries: 0, 4, 16..27, 29..31
  localparam logic [31:0] TRANSPARENT = 32'hEFFF_0011;

  typedef enum logic {
    HOLD_ST = 1'b0,
    STEP_ST = 1'b1
  } anim_state_t;

  typedef logic [4:0] ryu_index_t;

  // Sprite art image, addressed by flat ROM address
  function automatic ryu_index_t ryu_art(input logic [31:0] a);
    return 5'(a * 32'd13 + (a >> 5) * 32'd7);
  endfunction

endpackage

// File: rtl/ryu_sprite_rom.sv
// Synchronous sprite ROM, one cycle read latency.
// Holds the 5-bit colour index for every frame/row/column.
module ryu_sprite_rom
  import ryu_pkg::*;
#(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          ce_i,
  input  logic [AW-1:0] addr_i,
  output logic [4:0]    data_o
);

  // registered read, advances only with the pixel enable
  always_ff @(posedge clk) begin
    if (ce_i) begin
      data_o <= ryu_art(32'(addr_i));
    end
  end

endmodule

// File: rtl/ryu_sprite_fetch.sv
// Per-pixel sprite fetch: box test, flip, frame select.
// Position/facing/frame are latched per frame to avoid tearing.
module ryu_sprite_fetch
  import ryu_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int FRAMES = FRAMES_DEF,
  parameter int HOLD   = HOLD_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      pix_ce,
  input  logic                      frame_start,
  input  logic [9:0]                draw_x,
  input  logic [9:0]                draw_y,
  input  logic [9:0]                pos_x,
  input  logic [9:0]                pos_y,
  input  logic                      flip,
  input  logic                      anim_en,
  output logic [4:0]                index,
  output logic                      pixel_on,
  output logic [$clog2(FRAMES)-1:0] cur_frame
);

  localparam int AW = $clog2(FRAMES * SPR_W * SPR_H);
  localparam int CW = $clog2(SPR_W);
  localparam int FW = $clog2(FRAMES);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [9:0]         sx_q;
  logic [9:0]         sy_q;
  logic               flip_q;
  anim_state_t        state_q;
  anim_state_t        state_d;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_d;
  logic [FW-1:0]      frame_q;
  logic [FW-1:0]      frame_d;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic               in_box;
  logic [CW-1:0]      col;
  logic [AW-1:0]      addr_d;
  logic [AW-1:0]      addr_q;
  logic               in_box_q;
  logic               in_box_d1_q;
  logic [4:0]         rom_data;

  // shadow copy of position and facing, taken at vblank
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sx_q   <= '0;
      sy_q   <= '0;
      flip_q <= 1'b0;
    end else if (frame_start) begin
      sx_q   <= pos_x;
      sy_q   <= pos_y;
      flip_q <= flip;
    end
  end

  // animation state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD_ST;
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
    end
  end

  // animation next state: count vsyncs, step frame on wrap
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    if (state_q == STEP_ST) begin
      state_d = HOLD_ST;
    end
    if (frame_start) begin
      if (!anim_en) begin
        hold_d  = '0;
        state_d = HOLD_ST;
      end else if (hold_q == HW'(HOLD - 1)) begin
        hold_d  = '0;
        state_d = STEP_ST;
        frame_d = (frame_q == FW'(FRAMES - 1))
                ? '0 : frame_q + 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  // stage 0 combinational: signed offsets, box test, address
  always_comb begin
    dx = $signed({1'b0, draw_x}) - $signed({1'b0, sx_q});
    dy = $signed({1'b0, draw_y}) - $signed({1'b0, sy_q});
    in_box = !dx[10] && (dx[9:0] < 10'(SPR_W))
          && !dy[10] && (dy[9:0] < 10'(SPR_H));
    col = dx[CW-1:0] ^ {CW{flip_q}};
    addr_d = '0;
    if (in_box) begin
      addr_d = AW'(frame_q) * AW'(SPR_W * SPR_H)
             + AW'(dy[9:0]) * AW'(SPR_W)
             + AW'(col);
    end
  end

  // pipeline registers, frozen while pix_ce is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      in_box_q    <= 1'b0;
      in_box_d1_q <= 1'b0;
    end else if (pix_ce) begin
      addr_q      <= addr_d;
      in_box_q    <= in_box;
      in_box_d1_q <= in_box_q;
    end
  end

  ryu_sprite_rom #(
    .AW (AW)
  ) u_rom (
    .clk    (clk),
    .ce_i   (pix_ce),
    .addr_i (addr_q),
    .data_o (rom_data)
  );

  // output qualification and colour-key test
  always_comb begin
    index    = in_box_d1_q ? rom_data : 5'd0;
    pixel_on = in_box_d1_q && !TRANSPARENT[index];
  end

  assign cur_frame = frame_q;

endmodule

// File: tb/tb_ryu_sprite_fetch.sv
// Scoreboard bench for ryu_sprite_fetch.
// Reference model works from coordinates and plain arithmetic.
module tb_ryu_sprite_fetch;

  localparam int SW = 64;
  localparam int SH = 96;
  localparam int NF = 4;
  localparam int HD = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pix_ce;
  logic       frame_start;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       flip;
  logic       anim_en;
  logic [4:0] index;
  logic       pixel_on;
  logic [1:0] cur_frame;

  always #5 clk = ~clk;

  ryu_sprite_fetch #(
    .SPR_W  (SW),
    .SPR_H  (SH),
    .FRAMES (NF),
    .HOLD   (HD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_ce      (pix_ce),
    .frame_start (frame_start),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
    .flip        (flip),
    .anim_en     (anim_en),
    .index       (index),
    .pixel_on    (pixel_on),
    .cur_frame   (cur_frame)
  );

  typedef struct packed {
    logic [4:0] idx;
    logic       on;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   seen = 0;
  int   last_idx = 0;
  int   last_on = 0;

  // reference model state
  int m_sx, m_sy, m_fr, m_vs;
  int m_fl;

  function automatic int rom_model(int a);
    return (a * 13 + (a / 32) * 7) % 32;
  endfunction

  function automatic int is_clear(int v);
    return (v == 0 || v == 4 || (v >= 16 && v <= 27) || v >= 29) ? 1 : 0;
  endfunction

  task automatic check(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_fl = 0; m_fr = 0; m_vs = 0;
  endtask

  // one clk cycle of stimulus; called at posedge+1
  task automatic step(int x, int y, bit ce, bit fs);
    int xi, yi, dx, dy, col, v;
    exp_t e;
    draw_x = 10'(x);
    draw_y = 10'(y);
    pix_ce = ce;
    frame_start = fs;
    xi = int'(draw_x);
    yi = int'(draw_y);
    if (ce) begin
      dx = xi - m_sx;
      dy = yi - m_sy;
      e = '0;
      if (dx >= 0 && dx < SW && dy >= 0 && dy < SH) begin
        col = (m_fl != 0) ? (SW - 1 - dx) : dx;
        v = rom_model(m_fr * SW * SH + dy * SW + col);
        e.idx = 5'(v);
        e.on = (is_clear(v) == 0);
      end
      exp_q.push_back(e);
    end
    if (fs) begin
      m_sx = int'(pos_x);
      m_sy = int'(pos_y);
      m_fl = int'(flip);
      if (anim_en) begin
        m_vs++;
        if (m_vs == HD) begin
          m_vs = 0;
          m_fr = (m_fr + 1) % NF;
        end
      end else begin
        m_vs = 0;
      end
    end
    @(posedge clk);
    #1;
    if (fs) check("cur_frame", int'(cur_frame), m_fr);
  endtask

  task automatic do_reset(int cycles);
    reset_n = 1'b0;
    #1;
    check("rst_index", int'(index), 0);
    check("rst_pixel_on", int'(pixel_on), 0);
    check("rst_cur_frame", int'(cur_frame), 0);
    exp_q.delete();
    seen = 0;
    last_idx = 0;
    last_on = 0;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic find_val(int v, output int fx, output int fy);
    fx = m_sx;
    fy = m_sy;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        if (rom_model(m_fr * SW * SH + r * SW + c) == v) begin
          fx = m_sx + c;
          fy = m_sy + r;
          return;
        end
      end
    end
  endtask

  // monitor: pop one expectation per enabled edge once the pipe is full
  bit   ce_s;
  exp_t got;
  initial begin
    forever begin
      @(posedge clk);
      ce_s = pix_ce;
      if (reset_n) begin
        if (ce_s) seen++;
        @(negedge clk);
        if (reset_n) begin
          if (ce_s && seen >= 2) begin
            if (exp_q.size() == 0) begin
              check("sb_underflow", 0, 1);
            end else begin
              got = exp_q.pop_front();
              check("index", int'(index), int'(got.idx));
              check("pixel_on", int'(pixel_on), int'(got.on));
              last_idx = int'(got.idx);
              last_on = int'(got.on);
            end
          end else if (ce_s) begin
            check("warmup_index", int'(index), 0);
            check("warmup_pixel_on", int'(pixel_on), 0);
          end else begin
            check("hold_index", int'(index), last_idx);
            check("hold_pixel_on", int'(pixel_on), last_on);
          end
        end
      end
    end
  end

  int rx, ry, fx, fy;
  bit rfs, rce;

  initial begin
    reset_n = 1'b0;
    pix_ce = 1'b0;
    frame_start = 1'b0;
    draw_x = '0;
    draw_y = '0;
    pos_x = '0;
    pos_y = '0;
    flip = 1'b0;
    anim_en = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2);

    // in-box fetch, unflipped
    pos_x = 10'd100; pos_y = 10'd50; flip = 1'b0;
    step(0, 0, 0, 1);
    step(100, 50, 1, 0);
    step(163, 50, 1, 0);
    step(164, 50, 1, 0);
    step(99, 50, 1, 0);
    step(100, 145, 1, 0);
    step(100, 146, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // flipped
    flip = 1'b1;
    step(0, 0, 0, 1);
    step(100, 50, 1, 0);
    step(163, 50, 1, 0);
    step(130, 60, 1, 0);

    // mid-frame position change must not show until vblank
    pos_x = 10'd300; flip = 1'b0;
    step(100, 50, 1, 0);
    step(300, 50, 1, 0);
    step(130, 70, 1, 1);
    step(300, 50, 1, 0);
    step(100, 50, 1, 0);

    // colour-key entries inside the box
    pos_x = 10'd200; pos_y = 10'd100;
    step(0, 0, 0, 1);
    find_val(4, fx, fy);
    step(fx, fy, 1, 0);
    find_val(28, fx, fy);
    step(fx, fy, 1, 0);
    step(fx, fy, 0, 0);

    // right-edge clip and far-off positions
    pos_x = 10'd620; pos_y = 10'd100;
    step(0, 0, 0, 1);
    step(639, 100, 1, 0);
    step(639, 195, 1, 0);
    step(639, 196, 1, 0);
    step(619, 100, 1, 0);
    step(0, 100, 1, 0);
    pos_x = 10'd1000; pos_y = 10'd1000;
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(639, 479, 1, 0);
    step(5, 3, 1, 0);

    // reset in the middle of a scan line
    pos_x = 10'd100; pos_y = 10'd50;
    step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(100 + i * 7, 55, 1, 0);
    do_reset(2);
    for (int i = 0; i < 5; i++) step(10 + i, 10, 1, 0);

    // animation stepping, wrap and freeze
    do_reset(1);
    pos_x = 10'd100; pos_y = 10'd50; anim_en = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      step(0, 0, 0, 1);
      step(110, 60, 1, 0);
      if (i == 6) check("step_after_6", int'(cur_frame), 1);
      if (i == 24) check("wrap_after_24", int'(cur_frame), 0);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    anim_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 1);
      step(120 + i, 70, 1, 0);
    end
    check("frozen", int'(cur_frame), 1);
    anim_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 1);
      if (i == 5) check("still_held", int'(cur_frame), 1);
      if (i == 6) check("resumed", int'(cur_frame), 2);
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rfs = ($urandom_range(0, 29) == 0);
      if (rfs) begin
        pos_x = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(960, 1023))
                                           : 10'($urandom_range(0, 700));
        pos_y = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(960, 1023))
                                           : 10'($urandom_range(0, 500));
        flip = 1'($urandom_range(0, 1));
        anim_en = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 9) < 7) begin
        rx = m_sx + int'($urandom_range(0, 79)) - 8;
        ry = m_sy + int'($urandom_range(0, 111)) - 8;
      end else begin
        rx = int'($urandom_range(0, 1023));
        ry = int'($urandom_range(0, 1023));
      end
      rce = ($urandom_range(0, 3) != 0);
      step(rx & 1023, ry & 1023, rce, rfs);
    end

    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    @(negedge clk);
    #1;
    check("drain", exp_q.size(), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
